sram_axi_master_bridge: RTL and testbench
=========================================

Name: sram_axi_master_bridge

Overview:
- Initiator-side bridge: converts a simple single-port SRAM-like CPU request interface into AXI3 master channels AR/R/AW/W/B.
- Sits between the cpu7b core's memory port and the AXI interconnect; the far end is typically an AXI-to-SRAM responder.
- One outstanding transaction, single-beat bursts only.
- Latches request payload so the CPU side may change inputs after the address is accepted.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, fixed ID driven on arid/awid/wid.

Ports:
- aclk  in  1  clock
- areset  in  1  reset; one clock; reset is synchronous and active-high
- cpu_req  in  1  request valid
- cpu_wr  in  1  1=write, 0=read
- cpu_size  in  3  AXI size code (0/1/2)
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_wstrb  in  DATA_W/8  byte enables
- cpu_addr_ok  out  1  request accepted this cycle
- cpu_data_ok  out  1  read data valid / write completed (1-cycle pulse)
- cpu_rdata  out  DATA_W  read data, valid with cpu_data_ok
- cpu_err  out  1  nonzero rresp/bresp, valid with cpu_data_ok
- m_araddr/m_arid/m_arlen(4)/m_arsize(3)/m_arburst(2)/m_arlock(2)/m_arcache(4)/m_arprot(3)/m_arvalid  out; m_arready in
- m_rdata/m_rid/m_rresp(2)/m_rlast/m_rvalid  in; m_rready out
- m_awaddr/m_awid/m_awlen/m_awsize/m_awburst/m_awlock/m_awcache/m_awprot/m_awvalid  out; m_awready in
- m_wdata/m_wid/m_wstrb/m_wlast/m_wvalid  out; m_wready in
- m_bid/m_bresp(2)/m_bvalid  in; m_bready out

Behaviour:
- Constants: arlen/awlen=0, burst=INCR(01), lock=0, cache=0, prot=0, wlast=1, ids=AXI_ID.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: cpu_addr_ok=1. If cpu_req=1, latch addr/size/wdata/wstrb/wr and go to RD_ADDR (wr=0) or WR_REQ (wr=1). cpu_addr_ok=0 in every other state.
- RD_ADDR: m_arvalid=1 from the latched registers. On m_arready go to RD_DATA.
- RD_DATA: m_rready=1. On m_rvalid, register rdata and rresp, pulse cpu_data_ok the next cycle, return to IDLE.
  - rid is not checked; rlast is ignored, since there is one outstanding single-beat transaction.
- WR_REQ: m_awvalid=~aw_done and m_wvalid=~w_done, driven independently.
  - aw_done sets on awvalid&awready; w_done sets on wvalid&wready; either may complete first or both in the same cycle.
  - When both are done (including same-cycle completion), clear the flags and go to WR_RESP.
- WR_RESP: m_bready=1. On m_bvalid, register bresp, pulse cpu_data_ok the next cycle, return to IDLE.
- Latency: read = 1 (addr_ok) + AR wait + R wait + 1; minimum 3 cycles from cpu_req to cpu_data_ok with zero-wait slave.
- A new cpu_req is accepted in the same cycle cpu_data_ok pulses: FSM is already IDLE at that point.
- VALID stability: once asserted, AR/AW/W valids and payloads hold until their handshake. Payload comes from registers and never from live cpu_* inputs.
- cpu_err = (resp != 00), registered with the same timing as cpu_data_ok.
- Reset (synchronous, mid-transaction included): FSM→IDLE; all valids/readies 0; cpu_data_ok=0, cpu_err=0, cpu_rdata=0; aw_done/w_done=0. Payload registers need no reset.
- A cpu_req with cpu_wr=1 and cpu_wstrb=0 is still issued as a write.

Decomposition:
- Shared defines header: AXI burst/resp encodings (BURST_INCR, RESP_OKAY) and channel width macros matching existing L* width macros.
- FSM state encoding as local constants.
- Optional sub-module axi_wr_issue: the AW/W done-flag pair with the "both done" output.

Test Plan:
- Read, zero-wait slave: cpu_req, wr=0, addr=0x1C000010; slave returns rdata=0xDEADBEEF, rresp=00 → arvalid 1 cycle, araddr=0x1C000010, arsize=2, cpu_data_ok with rdata=0xDEADBEEF, err=0.
- Write, AW ready 3 cycles before W: addr=0x100, wdata=0x12345678, wstrb=0xF → awvalid drops after its handshake; wvalid holds until wready; bvalid → cpu_data_ok=1.
- Write, W ready before AW, and same-cycle AW/W ready → exactly one AW and one W handshake each, single cpu_data_ok.
- Backpressure: arready low 5 cycles while cpu_addr changes → araddr stable at the latched value; cpu_addr_ok=0 throughout.
- Error: bresp=10 → cpu_data_ok=1, cpu_err=1; following read with rresp=00 → cpu_err=0.
- Reset asserted in RD_DATA → next cycle arvalid=rready=0, cpu_addr_ok=1, no cpu_data_ok.

Source files
------------

// File: rtl/sram_axi_master_bridge_pkg.sv
// Shared types and AXI encodings for the SRAM-to-AXI3 master bridge.
// Holds the FSM state type, the fixed burst/response codes and the error decode.
package sram_axi_master_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] LEN_SINGLE = 4'd0;

    function automatic logic resp_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/sram_axi_master_bridge_wr_issue.sv
// Tracks completion of the AW and W handshakes of one write so the two
// channels can finish in any order, including in the same cycle.
module sram_axi_master_bridge_wr_issue (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic aw_hs,
    input  logic w_hs,
    output logic aw_done,
    output logic w_done,
    output logic both_done
);

    assign both_done = active && (aw_done || aw_hs) && (w_done || w_hs);

    always_ff @(posedge clk) begin
        if (rst || both_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (active) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/sram_axi_master_bridge.sv
// Converts a single-port SRAM-style CPU request into single-beat AXI3
// transactions, one outstanding at a time, with the request payload latched.
module sram_axi_master_bridge
    import sram_axi_master_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                cpu_req,
    input  logic                cpu_wr,
    input  logic [2:0]          cpu_size,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic                cpu_addr_ok,
    output logic                cpu_data_ok,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_err,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [ID_W-1:0]     m_arid,
    output logic [3:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic [1:0]          m_arlock,
    output logic [3:0]          m_arcache,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [ID_W-1:0]     m_awid,
    output logic [3:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic [1:0]          m_awlock,
    output logic [3:0]          m_awcache,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [ID_W-1:0]     m_wid,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          size_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done, w_done, both_done;

    // Single outstanding single-beat transfer: rid/bid/rlast carry no information.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{m_rid, m_rlast, m_bid};

    always_ff @(posedge aclk) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cpu_req)   state_nxt = cpu_wr ? ST_WR_REQ : ST_RD_ADDR;
            ST_RD_ADDR: if (m_arready) state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (m_rvalid)  state_nxt = ST_IDLE;
            ST_WR_REQ:  if (both_done) state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (m_bvalid)  state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_addr_ok = 1'b0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        case (state)
            ST_IDLE:    cpu_addr_ok = 1'b1;
            ST_RD_ADDR: m_arvalid   = 1'b1;
            ST_RD_DATA: m_rready    = 1'b1;
            ST_WR_REQ: begin
                m_awvalid = !aw_done;
                m_wvalid  = !w_done;
            end
            ST_WR_RESP: m_bready    = 1'b1;
            default: ;
        endcase
    end

    sram_axi_master_bridge_wr_issue u_wr_issue (
        .clk       (aclk),
        .rst       (areset),
        .active    (state == ST_WR_REQ),
        .aw_hs     (m_awvalid && m_awready),
        .w_hs      (m_wvalid && m_wready),
        .aw_done   (aw_done),
        .w_done    (w_done),
        .both_done (both_done)
    );

    // Payload is captured on acceptance so AXI payloads never follow live CPU inputs.
    always_ff @(posedge aclk) begin
        if (state == ST_IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            size_q  <= cpu_size;
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cpu_data_ok <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rdata   <= '0;
        end else begin
            cpu_data_ok <= 1'b0;
            if (state == ST_RD_DATA && m_rvalid) begin
                cpu_data_ok <= 1'b1;
                cpu_rdata   <= m_rdata;
                cpu_err     <= resp_err(m_rresp);
            end else if (state == ST_WR_RESP && m_bvalid) begin
                cpu_data_ok <= 1'b1;
                cpu_err     <= resp_err(m_bresp);
            end
        end
    end

    assign m_araddr  = addr_q;
    assign m_arid    = ID_W'(AXI_ID);
    assign m_arlen   = LEN_SINGLE;
    assign m_arsize  = size_q;
    assign m_arburst = BURST_INCR;
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'b0000;
    assign m_arprot  = 3'b000;

    assign m_awaddr  = addr_q;
    assign m_awid    = ID_W'(AXI_ID);
    assign m_awlen   = LEN_SINGLE;
    assign m_awsize  = size_q;
    assign m_awburst = BURST_INCR;
    assign m_awlock  = 2'b00;
    assign m_awcache = 4'b0000;
    assign m_awprot  = 3'b000;

    assign m_wdata   = wdata_q;
    assign m_wid     = ID_W'(AXI_ID);
    assign m_wstrb   = wstrb_q;
    assign m_wlast   = 1'b1;

endmodule

// File: tb/tb_sram_axi_master_bridge.sv
// Directed bench for sram_axi_master_bridge: stimulus tasks act as CPU and AXI
// slave, and a monitor matches every cpu_data_ok against a queue of expected responses.
module tb_sram_axi_master_bridge;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cpu_req, cpu_wr;
    logic [2:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_addr_ok, cpu_data_ok, cpu_err;
    logic [31:0] cpu_rdata;
    logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
    logic [3:0]  m_arid, m_awid, m_wid, m_rid, m_bid;
    logic [3:0]  m_arlen, m_awlen, m_arcache, m_awcache, m_wstrb;
    logic [2:0]  m_arsize, m_awsize, m_arprot, m_awprot;
    logic [1:0]  m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

    sram_axi_master_bridge dut (
        .aclk(aclk), .areset(areset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_addr_ok(cpu_addr_ok),
        .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wid(m_wid), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_exp = 0;
    int   data_ok_cnt = 0;
    int   ar_hs = 0, aw_hs = 0, w_hs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts handshakes and scores each response pulse against the queue.
    always @(negedge aclk) begin
        if (m_arvalid && m_arready) ar_hs++;
        if (m_awvalid && m_awready) aw_hs++;
        if (m_wvalid && m_wready)   w_hs++;
        if (cpu_data_ok === 1'b1) begin
            exp_t e;
            data_ok_cnt++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_data_ok: got 1 expected 0 at %0t", $time);
            end else begin
                e = q.pop_front();
                if (e.is_rd) chk("rdata", cpu_rdata, e.rdata);
                chk("cpu_err", cpu_err, e.err);
            end
        end
    end

    // Entered and left at posedge+1; returns in the cycle cpu_data_ok pulses.
    task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] rdata, input logic [1:0] rresp,
                           input int ar_wait, input int r_wait);
        int ar0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = addr; cpu_size = size;
        q.push_back('{1'b1, rdata, rresp != 2'b00});
        n_exp++;
        @(negedge aclk);
        chk("rd_addr_ok", cpu_addr_ok, 1);
        ar0 = ar_hs;
        @(posedge aclk); #1;
        cpu_req = 1'b0; cpu_addr = ~addr; cpu_size = 3'd0;
        for (int i = 0; i < ar_wait; i++) begin
            cpu_addr = $urandom;
            cpu_size = 3'($urandom_range(0, 2));
            @(negedge aclk);
            chk("arvalid_wait", m_arvalid, 1);
            chk("araddr_wait", m_araddr, addr);
            chk("addr_ok_busy", cpu_addr_ok, 0);
            @(posedge aclk); #1;
        end
        m_arready = 1'b1;
        @(negedge aclk);
        chk("arvalid", m_arvalid, 1);
        chk("araddr", m_araddr, addr);
        chk("arsize", m_arsize, size);
        chk("arburst", m_arburst, 2'b01);
        @(posedge aclk); #1;
        m_arready = 1'b0;
        chk("ar_hs_count", ar_hs - ar0, 1);
        for (int i = 0; i < r_wait; i++) begin
            @(negedge aclk);
            chk("rready_wait", m_rready, 1);
            @(posedge aclk); #1;
        end
        m_rvalid = 1'b1; m_rdata = rdata; m_rresp = rresp;
        m_rid = 4'hA; m_rlast = 1'b0;
        @(negedge aclk);
        chk("rready", m_rready, 1);
        chk("arvalid_off", m_arvalid, 0);
        @(posedge aclk); #1;
        m_rvalid = 1'b0; m_rdata = 32'h0BAD0BAD; m_rresp = 2'b11;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int aw_d, input int w_d,
                            input logic [1:0] bresp);
        int aw0, w0, last;
        last = (aw_d > w_d) ? aw_d : w_d;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = addr; cpu_size = 3'd2;
        cpu_wdata = wdata; cpu_wstrb = wstrb;
        q.push_back('{1'b0, 32'h0, bresp != 2'b00});
        n_exp++;
        @(negedge aclk);
        chk("wr_addr_ok", cpu_addr_ok, 1);
        aw0 = aw_hs; w0 = w_hs;
        @(posedge aclk); #1;
        cpu_req = 1'b0; cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_wstrb = ~wstrb;
        for (int c = 0; c <= last; c++) begin
            m_awready = (c == aw_d);
            m_wready  = (c == w_d);
            @(negedge aclk);
            chk("awvalid", m_awvalid, c <= aw_d);
            chk("wvalid", m_wvalid, c <= w_d);
            if (c <= aw_d) chk("awaddr", m_awaddr, addr);
            if (c <= w_d) begin
                chk("wdata", m_wdata, wdata);
                chk("wstrb", m_wstrb, wstrb);
            end
            @(posedge aclk); #1;
        end
        m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b1; m_bresp = bresp; m_bid = 4'h5;
        @(negedge aclk);
        chk("bready", m_bready, 1);
        chk("awvalid_resp", m_awvalid, 0);
        chk("wvalid_resp", m_wvalid, 0);
        @(posedge aclk); #1;
        m_bvalid = 1'b0; m_bresp = 2'b11;
        chk("aw_hs_count", aw_hs - aw0, 1);
        chk("w_hs_count", w_hs - w0, 1);
    endtask

    initial begin
        areset = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 3'd0;
        cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = '0; m_rlast = 1'b1;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("rst_addr_ok", cpu_addr_ok, 1);
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_awvalid", m_awvalid, 0);
        chk("rst_wvalid", m_wvalid, 0);
        chk("rst_rready", m_rready, 0);
        chk("rst_bready", m_bready, 0);
        chk("rst_data_ok", cpu_data_ok, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_wlast", m_wlast, 1);
        @(posedge aclk); #1;

        do_read(32'h1C000010, 3'd2, 32'hDEADBEEF, 2'b00, 0, 0);
        do_write(32'h00000100, 32'h12345678, 4'hF, 0, 3, 2'b00);
        do_write(32'h00000104, 32'hCAFEF00D, 4'h3, 2, 0, 2'b00);
        do_write(32'h00000108, 32'h0BADF00D, 4'hC, 1, 1, 2'b00);
        do_read(32'h20000040, 3'd1, 32'h1234ABCD, 2'b00, 5, 2);
        do_write(32'h00000300, 32'h11111111, 4'hF, 0, 0, 2'b10);
        do_read(32'h00000304, 3'd2, 32'h22222222, 2'b00, 0, 0);
        do_read(32'h00000308, 3'd0, 32'h33333333, 2'b11, 1, 1);
        do_write(32'h00000200, 32'hA5A5A5A5, 4'h0, 1, 0, 2'b00);

        // Reset while waiting for read data: no response may follow.
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h00000400; cpu_size = 3'd2;
        @(negedge aclk);
        @(posedge aclk); #1;
        cpu_req = 1'b0;
        m_arready = 1'b1;
        @(negedge aclk);
        @(posedge aclk); #1;
        m_arready = 1'b0;
        areset = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h55AA55AA; m_rresp = 2'b10;
        @(negedge aclk);
        chk("pre_rst_rready", m_rready, 1);
        @(posedge aclk); #1;
        areset = 1'b0; m_rvalid = 1'b0;
        @(negedge aclk);
        chk("mid_rst_arvalid", m_arvalid, 0);
        chk("mid_rst_rready", m_rready, 0);
        chk("mid_rst_addr_ok", cpu_addr_ok, 1);
        chk("mid_rst_data_ok", cpu_data_ok, 0);
        chk("mid_rst_rdata", cpu_rdata, 0);
        chk("mid_rst_err", cpu_err, 0);

        repeat (4) @(posedge aclk);
        #1;
        chk("pending_responses", q.size(), 0);
        chk("data_ok_count", data_ok_cnt, n_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
